// File: rtl/mm_batch_sequencer.sv
// rtl/mm_batch_sequencer.sv - sequences a matrix multiplier over a batch of B vectors
// Each job: hold mm_reset, pulse mm_enable, wait for busy then ready, advance addresses.
module mm_batch_sequencer #(
   parameter int B_STRIDE   = 512,
   parameter int X_STRIDE   = 512,
   parameter int CLR_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic [7:0]  num_jobs,
   input  logic [21:0] flash_base,
   input  logic [17:0] b_base,
   input  logic [17:0] x_base,
   input  logic [23:0] timeout_limit,
   output logic        mm_reset,
   output logic        mm_enable,
   output logic [21:0] mm_flashStartAddr,
   output logic [17:0] mm_sramStartAddr,
   output logic [17:0] mm_sramStoreAddr,
   input  logic        mm_busy,
   input  logic        mm_ready,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  jobs_done
);
   typedef enum logic [2:0] {
      IDLE, CLEAR, LAUNCH, WAIT_ACK, WAIT_READY, NEXT, DONE, FAULT
   } state_t;

   localparam logic [17:0] B_STEP   = 18'(B_STRIDE);
   localparam logic [17:0] X_STEP   = 18'(X_STRIDE);
   localparam logic [7:0]  CLR_LOAD = 8'(CLR_CYCLES - 1);

   state_t      r_state;
   logic [7:0]  r_clr_cnt;
   logic [7:0]  r_num_jobs;
   logic [23:0] r_timeout_limit;
   logic [23:0] r_wait_cnt;
   logic [23:0] w_wait_inc;
   logic        w_timeout;
   logic        w_abort;
   logic [7:0]  w_jobs_inc;

   assign w_wait_inc = (r_wait_cnt == 24'hFFFFFF) ? r_wait_cnt : r_wait_cnt + 24'd1;
   assign w_timeout  = (r_timeout_limit != 24'd0) && (w_wait_inc == r_timeout_limit);
   assign w_abort    = abort && (r_state inside {CLEAR, LAUNCH, WAIT_ACK, WAIT_READY, NEXT});
   assign w_jobs_inc = jobs_done + 8'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state           <= IDLE;
         r_clr_cnt         <= CLR_LOAD;
         r_num_jobs        <= 8'd0;
         r_timeout_limit   <= 24'd0;
         r_wait_cnt        <= 24'd0;
         mm_reset          <= 1'b1;
         mm_enable         <= 1'b0;
         mm_flashStartAddr <= 22'd0;
         mm_sramStartAddr  <= 18'd0;
         mm_sramStoreAddr  <= 18'd0;
         busy              <= 1'b0;
         done              <= 1'b0;
         error             <= 1'b0;
         jobs_done         <= 8'd0;
      end else begin
         done <= 1'b0;
         if (w_abort) begin
            // A job that already saw ready still counts as completed.
            mm_enable <= 1'b0;
            mm_reset  <= 1'b1;
            r_clr_cnt <= CLR_LOAD;
            busy      <= 1'b0;
            r_state   <= IDLE;
            if (r_state == NEXT) jobs_done <= w_jobs_inc;
         end else begin
            case (r_state)
               IDLE: begin
                  mm_reset <= (r_clr_cnt != 8'd0);
                  if (r_clr_cnt != 8'd0) r_clr_cnt <= r_clr_cnt - 8'd1;
                  if (start) begin
                     error     <= 1'b0;
                     jobs_done <= 8'd0;
                     if (num_jobs == 8'd0) begin
                        done <= 1'b1;
                     end else begin
                        r_num_jobs        <= num_jobs;
                        r_timeout_limit   <= timeout_limit;
                        mm_flashStartAddr <= flash_base;
                        mm_sramStartAddr  <= b_base;
                        mm_sramStoreAddr  <= x_base;
                        busy              <= 1'b1;
                        mm_reset          <= 1'b1;
                        r_clr_cnt         <= CLR_LOAD;
                        r_state           <= CLEAR;
                     end
                  end
               end
               CLEAR: begin
                  if (r_clr_cnt == 8'd0) begin
                     mm_reset  <= 1'b0;
                     mm_enable <= 1'b1;
                     r_state   <= LAUNCH;
                  end else begin
                     r_clr_cnt <= r_clr_cnt - 8'd1;
                  end
               end
               LAUNCH: begin
                  mm_enable  <= 1'b0;
                  r_wait_cnt <= 24'd0;
                  r_state    <= WAIT_ACK;
               end
               // Timeout is checked before busy so it cannot be skipped on the handoff cycle.
               WAIT_ACK, WAIT_READY: begin
                  r_wait_cnt <= w_wait_inc;
                  if (r_state == WAIT_READY && mm_ready) begin
                     r_state <= NEXT;
                  end else if (w_timeout) begin
                     error     <= 1'b1;
                     mm_reset  <= 1'b1;
                     r_clr_cnt <= CLR_LOAD;
                     r_state   <= FAULT;
                  end else if (r_state == WAIT_ACK && mm_busy) begin
                     r_state <= WAIT_READY;
                  end
               end
               NEXT: begin
                  jobs_done <= w_jobs_inc;
                  if (w_jobs_inc == r_num_jobs) begin
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     r_state <= DONE;
                  end else begin
                     mm_sramStartAddr <= mm_sramStartAddr + B_STEP;
                     mm_sramStoreAddr <= mm_sramStoreAddr + X_STEP;
                     mm_reset         <= 1'b1;
                     r_clr_cnt        <= CLR_LOAD;
                     r_state          <= CLEAR;
                  end
               end
               DONE: r_state <= IDLE;
               FAULT: begin
                  if (r_clr_cnt == 8'd0) begin
                     mm_reset <= 1'b0;
                     done     <= 1'b1;
                     busy     <= 1'b0;
                     r_state  <= IDLE;
                  end else begin
                     r_clr_cnt <= r_clr_cnt - 8'd1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end
endmodule
